// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU bus: a word-addressed RAM that holds
// both instructions and data, plus an MMIO window with LED, cycle counter and timer.
module mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  led,
  output logic        timer_irq
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  localparam logic [29:0] OFF_LED   = 30'd0;
  localparam logic [29:0] OFF_CYCLE = 30'd1;
  localparam logic [29:0] OFF_LOAD  = 30'd2;
  localparam logic [29:0] OFF_CTRL  = 30'd3;
  localparam logic [29:0] OFF_COUNT = 30'd4;

  typedef enum logic [1:0] {
    T_IDLE = 2'b00,
    T_RUN  = 2'b01,
    T_DONE = 2'b10
  } tstate_e;

  // ---------------------------------------------------------------- decode
  logic          is_io;
  logic [31:0]   io_off;
  logic [29:0]   io_word;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          wr_led;
  logic          wr_load;
  logic          wr_ctrl;
  logic          unused_ok;

  assign is_io     = (addr >= IO_BASE);
  assign io_off    = addr - IO_BASE;
  assign io_word   = io_off[31:2];
  assign ram_idx   = addr[AW+1:2];
  assign ram_we    = memwrite && !is_io;
  assign wr_led    = memwrite && is_io && (io_word == OFF_LED);
  assign wr_load   = memwrite && is_io && (io_word == OFF_LOAD);
  assign wr_ctrl   = memwrite && is_io && (io_word == OFF_CTRL);
  assign unused_ok = ^io_off[1:0];

  // ---------------------------------------------------------------- RAM
  // Read is combinational so the multicycle core sees data in the same cycle it
  // presents the address; contents are deliberately left out of reset.
  logic [31:0] ram_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wd;
    end
  end

  // ---------------------------------------------------------------- registers
  logic [7:0]  led_q,   led_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] load_q,  load_d;
  logic [31:0] count_q, count_d;
  logic        en_q,    en_d;
  logic        auto_q,  auto_d;
  logic        exp_q,   exp_d;
  tstate_e     state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= '0;
      cycle_q <= '0;
      load_q  <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      exp_q   <= 1'b0;
      state_q <= T_IDLE;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      exp_q   <= exp_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    led_d   = led_q;
    cycle_d = cycle_q + 32'd1;
    if (wr_led) begin
      led_d = wd[7:0];
    end
  end

  // ---------------------------------------------------------------- timer FSM
  logic expire;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load_d  = load_q;
    en_d    = en_q;
    auto_d  = auto_q;
    exp_d   = exp_q;
    expire  = 1'b0;

    if (wr_load) begin
      load_d = wd;
    end

    if (state_q == T_RUN && count_q != 32'd0) begin
      count_d = count_q - 32'd1;
      if (count_q == 32'd1) begin
        expire = 1'b1;
        if (auto_q) begin
          count_d = load_q;
        end else begin
          state_d = T_DONE;
          en_d    = 1'b0;
        end
      end
    end

    // A bus write to LOAD or CTRL overrides whatever the decrement computed.
    if (wr_load) begin
      count_d = wd;
    end

    if (wr_ctrl) begin
      auto_d  = wd[1];
      count_d = count_q;
      if (wd[0] && load_q != 32'd0) begin
        state_d = T_RUN;
        en_d    = 1'b1;
        count_d = load_q;
      end else begin
        // Stopping (or refusing to start with LOAD==0) never counts as an expiry.
        en_d    = 1'b0;
        expire  = 1'b0;
        state_d = (state_q == T_RUN) ? T_IDLE : state_q;
      end
      if (wd[2]) begin
        exp_d = 1'b0;
      end
    end

    // Set after the write-1 clear so a simultaneous hardware expiry wins.
    if (expire) begin
      exp_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------- read mux
  always_comb begin
    rd = ram_q[ram_idx];
    if (is_io) begin
      case (io_word)
        OFF_LED:   rd = {24'd0, led_q};
        OFF_CYCLE: rd = cycle_q;
        OFF_LOAD:  rd = load_q;
        OFF_CTRL:  rd = {27'd0, state_q, exp_q, auto_q, en_q};
        OFF_COUNT: rd = count_q;
        default:   rd = 32'd0;
      endcase
    end
  end

  assign led       = led_q;
  assign timer_irq = exp_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: expected values are queued when
// the stimulus is applied and popped when the DUT output is sampled.
module tb_mem_responder;

  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_LED   = IO_BASE + 32'h00;
  localparam logic [31:0] A_CYCLE = IO_BASE + 32'h04;
  localparam logic [31:0] A_LOAD  = IO_BASE + 32'h08;
  localparam logic [31:0] A_CTRL  = IO_BASE + 32'h0C;
  localparam logic [31:0] A_COUNT = IO_BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [7:0]  led;
  logic        timer_irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb_q[$];
  logic [31:0] tb_cyc;

  mem_responder #(.MEM_WORDS(1024), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .wd(wd),
    .rd(rd), .led(led), .timer_irq(timer_irq)
  );

  always #10 clk = ~clk;

  // Reference model of the free-running cycle counter.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic push(input logic [31:0] e);
    sb_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    memwrite = 1'b0;
    addr = a;
    push(e);
    #1;
    chk(tag, rd);
  endtask

  task automatic out_chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    push(e);
    chk(tag, obs);
  endtask

  // Drive a write for the next rising edge; returns just after the following falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    addr = a;
    wd = d;
    @(negedge clk);
    memwrite = 1'b0;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #3;
    out_chk("rst_led", {24'd0, led}, 32'd0);
    out_chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    rd_chk("rst_ctrl", A_CTRL, 32'd0);
    rd_chk("rst_count", A_COUNT, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // EN=1 with LOAD==0 stays idle and EN reads back 0
    wr(A_CTRL, 32'h1);
    rd_chk("en_noload_ctrl", A_CTRL, 32'd0);

    // RAM write/read, byte-offset and aliasing
    wr(32'h40, 32'hDEAD_BEEF);
    wr(32'h44, 32'h0BAD_F00D);
    rd_chk("ram_40", 32'h40, 32'hDEAD_BEEF);
    rd_chk("ram_42", 32'h42, 32'hDEAD_BEEF);
    rd_chk("ram_44", 32'h44, 32'h0BAD_F00D);
    rd_chk("ram_alias", 32'h40 + 32'd4096, 32'hDEAD_BEEF);

    // LED register
    wr(A_LED, 32'h1234_56A5);
    out_chk("led_out", {24'd0, led}, 32'hA5);
    rd_chk("led_rd", A_LED, 32'h0000_00A5);
    rd_chk("led_rd_b2", A_LED + 32'd2, 32'h0000_00A5);

    // one-shot timer: LOAD=3, CTRL=1 at edge T
    wr(A_LOAD, 32'd3);
    rd_chk("load_rd", A_LOAD, 32'd3);
    wr(A_CTRL, 32'h1);
    rd_chk("os_cnt_T", A_COUNT, 32'd3);
    step();
    rd_chk("os_cnt_T1", A_COUNT, 32'd2);
    step();
    rd_chk("os_cnt_T2", A_COUNT, 32'd1);
    out_chk("os_irq_T2", {31'd0, timer_irq}, 32'd0);
    step();
    rd_chk("os_cnt_T3", A_COUNT, 32'd0);
    out_chk("os_irq_T3", {31'd0, timer_irq}, 32'd1);
    rd_chk("os_ctrl_done", A_CTRL, 32'h14);
    step();
    rd_chk("os_cnt_hold", A_COUNT, 32'd0);
    wr(A_CTRL, 32'h4);
    out_chk("os_irq_clr", {31'd0, timer_irq}, 32'd0);
    rd_chk("os_ctrl_clr", A_CTRL, 32'h10);

    // auto-reload timer: LOAD=2, CTRL=3
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h3);
    rd_chk("ar_cnt_T", A_COUNT, 32'd2);
    step();
    rd_chk("ar_cnt_T1", A_COUNT, 32'd1);
    out_chk("ar_irq_T1", {31'd0, timer_irq}, 32'd0);
    step();
    out_chk("ar_irq_T2", {31'd0, timer_irq}, 32'd1);
    rd_chk("ar_cnt_T2", A_COUNT, 32'd2);
    rd_chk("ar_ctrl_T2", A_CTRL, 32'h0F);
    step();
    rd_chk("ar_cnt_T3", A_COUNT, 32'd1);
    wr(A_CTRL, 32'h7);
    out_chk("ar_exp_wins", {31'd0, timer_irq}, 32'd1);
    rd_chk("ar_cnt_T4", A_COUNT, 32'd2);
    wr(A_CTRL, 32'h7);
    out_chk("ar_exp_clr", {31'd0, timer_irq}, 32'd0);
    wr(A_CTRL, 32'h0);
    rd_chk("stop_ctrl", A_CTRL, 32'd0);
    rd_chk("stop_cnt", A_COUNT, 32'd2);
    step();
    rd_chk("stop_cnt_frz", A_COUNT, 32'd2);

    // cycle counter is read-only and free-running; unmapped offsets read 0
    rd_chk("cyc_a", A_CYCLE, tb_cyc);
    wr(A_CYCLE, 32'h5555_5555);
    repeat (4) step();
    rd_chk("cyc_b", A_CYCLE, tb_cyc);
    rd_chk("unmapped_20", IO_BASE + 32'h20, 32'd0);
    rd_chk("unmapped_14", IO_BASE + 32'h14, 32'd0);

    // reset mid-count
    wr(A_LOAD, 32'd9);
    wr(A_CTRL, 32'h1);
    step();
    step();
    rd_chk("pre_rst_cnt", A_COUNT, 32'd7);
    #2;
    reset = 1'b1;
    #1;
    out_chk("rst_mid_led", {24'd0, led}, 32'd0);
    out_chk("rst_mid_irq", {31'd0, timer_irq}, 32'd0);
    rd_chk("rst_mid_ctrl", A_CTRL, 32'd0);
    rd_chk("rst_mid_cnt", A_COUNT, 32'd0);
    rd_chk("rst_mid_load", A_LOAD, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) step();
    out_chk("post_rst_irq", {31'd0, timer_irq}, 32'd0);
    rd_chk("post_rst_ctrl", A_CTRL, 32'd0);
    rd_chk("post_rst_ram", 32'h40, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
